// File: rtl/gold_event_ctrl.sv
// Gold bag event controller: accumulates per-frame overlap and support information.
// Results are committed one cycle after frame start, and the controller runs the digger eat handshake.
module gold_event_ctrl #(
   parameter int SUPPORT_MIN = 4,
   parameter int FLOOR_Y     = 448
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        gold_dr,
   input  logic        digger_dr,
   input  logic        monster_dr,
   input  logic        dirt_dr,
   input  logic [10:0] goldTLX,
   input  logic [10:0] goldTLY,
   input  logic [3:0]  gold_state,
   output logic        collision,
   output logic        been_eaten,
   output logic        can_fall,
   output logic        monster_kill,
   output logic        digger_kill,
   output logic        score_add
);

   typedef enum logic [3:0] {
      G_REST   = 4'd0,
      G_WOBBLE = 4'd1,
      G_FALL   = 4'd2,
      G_GONE   = 4'd3,
      G_BROKEN = 4'd4
   } gold_state_e;

   typedef enum logic [1:0] {
      E_IDLE,
      E_REQ,
      E_DONE
   } eat_state_e;

   logic [11:0] sup_row;
   logic [11:0] x_hi;
   logic        ev_dg;
   logic        ev_mn;
   logic        ev_sup;

   logic        dg_hit_q, dg_hit_d;
   logic        mn_hit_q, mn_hit_d;
   logic [5:0]  sup_cnt_q, sup_cnt_d;
   logic        snap_dg_q;
   logic        snap_mn_q;
   logic [5:0]  snap_sup_q;
   logic        commit_q;

   eat_state_e  eat_q;
   logic [1:0]  req_cnt_q;

   logic        pushable;
   logic        fall_ok;
   logic        falling;
   logic        broken;
   logic        gone;
   logic        under_support;
   logic        above_floor;

   // 12-bit sums: a support row past 2047 can never equal an 11-bit pixelY.
   assign sup_row = {1'b0, goldTLY} + 12'd32;
   assign x_hi    = {1'b0, goldTLX} + 12'd31;

   assign ev_dg  = gold_dr && digger_dr;
   assign ev_mn  = gold_dr && monster_dr;
   assign ev_sup = dirt_dr && ({1'b0, pixelY} == sup_row) &&
                   ({1'b0, pixelX} >= {1'b0, goldTLX}) && ({1'b0, pixelX} <= x_hi);

   always_comb begin
      // NOTE: defaults first so every path assigns each signal and no latch is inferred.
      dg_hit_d  = dg_hit_q | ev_dg;
      mn_hit_d  = mn_hit_q | ev_mn;
      sup_cnt_d = sup_cnt_q;
      if (ev_sup && (sup_cnt_q != 6'd63)) begin
         sup_cnt_d = sup_cnt_q + 6'd1;
      end
      // Frame start restarts accumulation with this cycle's own events.
      if (startOfFrame) begin
         dg_hit_d  = ev_dg;
         mn_hit_d  = ev_mn;
         sup_cnt_d = {5'd0, ev_sup};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dg_hit_q   <= 1'b0;
         mn_hit_q   <= 1'b0;
         sup_cnt_q  <= 6'd0;
         snap_dg_q  <= 1'b0;
         snap_mn_q  <= 1'b0;
         snap_sup_q <= 6'd0;
         commit_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         dg_hit_q  <= dg_hit_d;
         mn_hit_q  <= mn_hit_d;
         sup_cnt_q <= sup_cnt_d;
         commit_q  <= startOfFrame;
         if (startOfFrame) begin
            snap_dg_q  <= dg_hit_q;
            snap_mn_q  <= mn_hit_q;
            snap_sup_q <= sup_cnt_q;
         end
      end
   end

   assign pushable      = (gold_state == G_REST) || (gold_state == G_WOBBLE);
   assign fall_ok       = pushable || (gold_state == G_FALL);
   assign falling       = (gold_state == G_FALL);
   assign broken        = (gold_state == G_BROKEN);
   assign gone          = (gold_state == G_GONE);
   assign under_support = int'(snap_sup_q) < SUPPORT_MIN;
   assign above_floor   = int'(goldTLY) < FLOOR_Y;

   // Kill pulses are suppressed for one cycle after firing, so back-to-back commits cannot stretch them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         collision    <= 1'b0;
         can_fall     <= 1'b0;
         monster_kill <= 1'b0;
         digger_kill  <= 1'b0;
      end else begin
         monster_kill <= commit_q && snap_mn_q && falling && !monster_kill;
         digger_kill  <= commit_q && snap_dg_q && falling && !digger_kill;
         if (commit_q) begin
            collision <= snap_dg_q && pushable;
            can_fall  <= under_support && above_floor && fall_ok;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         eat_q      <= E_IDLE;
         req_cnt_q  <= 2'd0;
         been_eaten <= 1'b0;
         score_add  <= 1'b0;
      end else begin
         score_add <= 1'b0;
         case (eat_q)
            E_IDLE: begin
               if (commit_q && snap_dg_q && broken) begin
                  eat_q      <= E_REQ;
                  req_cnt_q  <= 2'd0;
                  been_eaten <= 1'b1;
               end
            end
            E_REQ: begin
               if (gone) begin
                  eat_q      <= E_DONE;
                  been_eaten <= 1'b0;
                  score_add  <= 1'b1;
               end else if (commit_q) begin
                  // Give up after the fourth commit seen while requesting.
                  if (req_cnt_q == 2'd3) begin
                     eat_q      <= E_IDLE;
                     been_eaten <= 1'b0;
                  end else begin
                     req_cnt_q <= req_cnt_q + 2'd1;
                  end
               end
            end
            E_DONE: begin
               if (!gone) begin
                  eat_q <= E_IDLE;
               end
            end
            default: begin
               eat_q      <= E_IDLE;
               been_eaten <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/gold_event_ctrl.md
GOLD_EVENT_CTRL -- requirements
Module: gold_event_ctrl

Interface
REQ-001 Parameter SUPPORT_MIN, default 4: minimum dirt pixels under the bag that hold it up.
REQ-002 Parameter FLOOR_Y, default 448: gold top-left Y at or beyond which the bag rests on the floor.
REQ-003 clk  input  1  system clock; the single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 startOfFrame  input  1  one-cycle pulse at each frame start.
REQ-006 pixelX, pixelY  input  11 each  current scan pixel.
REQ-007 gold_dr, digger_dr, monster_dr, dirt_dr  input  1 each  per-pixel drawing requests.
REQ-008 goldTLX, goldTLY  input  11 each  gold bag top-left corner.
REQ-009 gold_state  input  4  bag state: 0 REST, 1 WOBBLE, 2 FALL, 3 GONE, 4 BROKEN; any other value is NONE.
REQ-010 collision  output  1  level: digger is pushing the bag (REST or WOBBLE).
REQ-011 been_eaten  output  1  level: eat request to the bag.
REQ-012 can_fall  output  1  level: bag lacks support.
REQ-013 monster_kill, digger_kill, score_add  output  1 each  one-cycle pulses.

Function
REQ-014 The block SHALL accumulate the following during each frame:
- dg_hit: gold_dr && digger_dr.
- mn_hit: gold_dr && monster_dr.
- sup_cnt: 6-bit count that saturates at 63 and increments when dirt_dr && pixelY == goldTLY+32 (12-bit sum) && goldTLX <= pixelX <= goldTLX+31 (12-bit compare).
REQ-015 Commit SHALL occur on the cycle after startOfFrame. At commit, outputs SHALL update from the previous frame's accumulators.
REQ-016 On the startOfFrame cycle, accumulators SHALL clear, and that cycle's pixel events SHALL count toward the new frame.
REQ-017 At commit, collision SHALL equal dg_hit && gold_state in {REST, WOBBLE}, and SHALL hold until the next commit.
REQ-018 At commit, can_fall SHALL equal (sup_cnt < SUPPORT_MIN) && (goldTLY < FLOOR_Y) && gold_state in {REST, WOBBLE, FALL}, and SHALL hold until the next commit.
REQ-019 A goldTLY+32 sum above 2047 SHALL match no pixel row, so sup_cnt stays 0.
REQ-020 At commit, monster_kill SHALL pulse iff mn_hit && gold_state == FALL.
REQ-021 At commit, digger_kill SHALL pulse iff dg_hit && gold_state == FALL.
REQ-022 Eat FSM states SHALL be E_IDLE, E_REQ, E_DONE; been_eaten SHALL be 1 only in E_REQ.
REQ-023 E_IDLE SHALL go to E_REQ at commit when dg_hit && gold_state == BROKEN.
REQ-024 E_REQ transitions SHALL be:
- On the first cycle with gold_state == GONE: go to E_DONE and pulse score_add exactly one cycle.
- Otherwise, after 4 commits in E_REQ without GONE: return to E_IDLE with no score pulse.
REQ-025 E_DONE SHALL go to E_IDLE on the first cycle with gold_state != GONE. No further score_add SHALL occur while in E_DONE.
REQ-026 GONE observed outside E_REQ SHALL produce no score_add.
REQ-027 NONE state SHALL suppress collision, can_fall, kills and eat entry.
REQ-028 startOfFrame arriving on a commit cycle SHALL begin a new accumulation and schedule the next commit one cycle later. Kill pulses SHALL never exceed one cycle.

Reset
REQ-029 While reset is high: all outputs 0, accumulators 0, FSM in E_IDLE, no commit pending.
REQ-030 Reset asserted mid-frame or mid-handshake SHALL discard pending events.
REQ-031 The first commit after reset release SHALL use only events seen after release.

Verification
REQ-032 REST, 32 dirt pixels in the support row, no digger -> at commit collision=0, can_fall=0.
REQ-033 REST, 2 dirt pixels in the support row, goldTLY=100 -> can_fall=1 at commit; with goldTLY=448 -> can_fall=0.
REQ-034 FALL with monster overlap and digger overlap in one frame -> monster_kill and digger_kill both high exactly one cycle at commit.
REQ-035 BROKEN with digger overlap -> been_eaten=1 from commit; gold_state=3 three cycles later -> been_eaten=0 and score_add high one cycle; gold_state held at 3 for 10 frames -> no further score_add.
REQ-036 BROKEN eat request while gold_state never reaches GONE -> been_eaten drops after the 4th commit, score_add stays 0.
REQ-037 Reset pulsed mid-frame after a digger overlap -> next commit shows collision=0, all pulses 0.
